// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: decode control bundle, opcode constants and the halt FSM encoding.
package riscv_pipe_pkg;

    typedef struct packed {
        logic       ALUSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic [1:0] ALUOp;
        logic       Branch;
        logic       Jump;
        logic       JumpReg;
        logic       Halt;
    } ctrl_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_e;

    // A HALT travels down the pipe as an inert bundle so it can neither write nor touch memory.
    function automatic ctrl_t halt_only_ctrl();
        ctrl_t c;
        c      = '0;
        c.Halt = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection against the instruction currently held in EX.
module hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       flush_i,
    input  logic       run_i,
    output logic       stall_o
);

    logic hz;

    assign hz = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) & id_valid_i &
                ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

    // A flush kills the dependent instruction anyway, so stalling for it would only waste a cycle.
    assign stall_o = hz & ~flush_i & run_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and the halt-drain state machine.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int PC_W         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  ctrl_t             id_ctrl,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              flush,
    output logic              ex_valid,
    output ctrl_t             ex_ctrl,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall,
    output logic              fetch_stop,
    output logic              halted
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    halt_state_e       state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [6:0]        funct7_q, funct7_d;

    logic              run;
    logic              capture;

    assign run     = (state_q == RUN);
    assign capture = run & ~flush & ~stall;

    hazard_detect u_hazard (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.MemRead),
        .ex_rd_i       (rd_q),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .flush_i       (flush),
        .run_i         (run),
        .stall_o       (stall)
    );

    always_comb begin
        valid_d  = 1'b0;
        ctrl_d   = '0;
        pc_d     = '0;
        rd1_d    = '0;
        rd2_d    = '0;
        imm_d    = '0;
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        funct3_d = '0;
        funct7_d = '0;
        if (capture) begin
            valid_d  = id_valid;
            ctrl_d   = (id_valid & id_ctrl.Halt) ? halt_only_ctrl() : id_ctrl;
            pc_d     = id_pc;
            rd1_d    = id_rd1;
            rd2_d    = id_rd2;
            imm_d    = id_imm;
            rs1_d    = id_rs1;
            rs2_d    = id_rs2;
            rd_d     = id_rd;
            funct3_d = id_funct3;
            funct7_d = id_funct7;
        end
    end

    // A flush while the HALT itself is still in EX means an older branch squashed it; later flushes are stale.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            RUN: begin
                if (capture & id_valid & id_ctrl.Halt) begin
                    state_d = DRAIN;
                    count_d = '0;
                end
            end
            DRAIN: begin
                count_d = count_q + CNT_W'(1);
                if (flush && (count_q == '0)) begin
                    state_d = RUN;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            pc_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_pc      = pc_q;
    assign ex_rd1     = rd1_q;
    assign ex_rd2     = rd2_q;
    assign ex_imm     = imm_q;
    assign ex_rs1     = rs1_q;
    assign ex_rs2     = rs2_q;
    assign ex_rd      = rd_q;
    assign ex_funct3  = funct3_q;
    assign ex_funct7  = funct7_q;
    assign fetch_stop = (state_q != RUN);
    assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios checked against a cycle-level model plus literal expectations.
module tb_id_ex_stage;
    import riscv_pipe_pkg::*;

    localparam int DATA_W       = 32;
    localparam int PC_W         = 32;
    localparam int DRAIN_CYCLES = 3;

    // Control bundles: {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp[1:0],Branch,Jump,JumpReg,Halt}
    localparam logic [10:0] C_LW        = 11'b1111_0_00_0_0_0_0;
    localparam logic [10:0] C_ADD       = 11'b0010_0_10_0_0_0_0;
    localparam logic [10:0] C_HALT      = 11'b0010_0_00_0_0_0_1;
    localparam logic [10:0] C_HALT_ONLY = 11'b0000_0_00_0_0_0_1;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    ctrl_t             id_ctrl;
    logic [PC_W-1:0]   id_pc;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [2:0]        id_funct3;
    logic [6:0]        id_funct7;
    logic              flush;
    logic              ex_valid;
    ctrl_t             ex_ctrl;
    logic [PC_W-1:0]   ex_pc;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [2:0]        ex_funct3;
    logic [6:0]        ex_funct7;
    logic              stall, fetch_stop, halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .flush(flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .stall(stall), .fetch_stop(fetch_stop), .halted(halted)
    );

    // Model: the EX slot as a record, and the halt tracked as the cycle the HALT entered EX.
    typedef struct {
        logic        v;
        logic [10:0] c;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } slot_t;

    slot_t mEx;
    int    mCycle  = 0;
    int    mHaltAt = -1;

    function automatic slot_t bubbleSlot();
        slot_t s;
        s.v = 1'b0; s.c = '0; s.pc = '0; s.rd1 = '0; s.rd2 = '0; s.imm = '0;
        s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.f3 = '0; s.f7 = '0;
        return s;
    endfunction

    function automatic logic modelStall();
        if (mHaltAt >= 0 || flush) return 1'b0;
        return mEx.v && mEx.c[7] && (mEx.rd != 5'd0) && id_valid &&
               (mEx.rd == id_rs1 || mEx.rd == id_rs2);
    endfunction

    function automatic slot_t nextSlot();
        slot_t s;
        s = bubbleSlot();
        if (mHaltAt < 0 && !flush && !modelStall()) begin
            s.v = id_valid; s.c = id_ctrl; s.pc = id_pc;
            s.rd1 = id_rd1; s.rd2 = id_rd2; s.imm = id_imm;
            s.rs1 = id_rs1; s.rs2 = id_rs2; s.rd = id_rd;
            s.f3 = id_funct3; s.f7 = id_funct7;
            if (id_valid && id_ctrl.Halt) s.c = C_HALT_ONLY;
        end
        return s;
    endfunction

    function automatic int nextHaltAt();
        if (mHaltAt >= 0) return (flush && mCycle == mHaltAt) ? -1 : mHaltAt;
        if (!flush && !modelStall() && id_valid && id_ctrl.Halt) return mCycle + 1;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mEx     <= bubbleSlot();
            mHaltAt <= -1;
            mCycle  <= 0;
        end else begin
            mEx     <= nextSlot();
            mHaltAt <= nextHaltAt();
            mCycle  <= mCycle + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checkOutput("m_ex_valid",   ex_valid,   mEx.v);
            checkOutput("m_ex_ctrl",    ex_ctrl,    mEx.c);
            checkOutput("m_ex_pc",      ex_pc,      mEx.pc);
            checkOutput("m_ex_rd1",     ex_rd1,     mEx.rd1);
            checkOutput("m_ex_rd2",     ex_rd2,     mEx.rd2);
            checkOutput("m_ex_imm",     ex_imm,     mEx.imm);
            checkOutput("m_ex_rs1",     ex_rs1,     mEx.rs1);
            checkOutput("m_ex_rs2",     ex_rs2,     mEx.rs2);
            checkOutput("m_ex_rd",      ex_rd,      mEx.rd);
            checkOutput("m_ex_funct3",  ex_funct3,  mEx.f3);
            checkOutput("m_ex_funct7",  ex_funct7,  mEx.f7);
            checkOutput("m_stall",      stall,      modelStall());
            checkOutput("m_fetch_stop", fetch_stop, mHaltAt >= 0);
            checkOutput("m_halted",     halted,
                        (mHaltAt >= 0) && (mCycle - mHaltAt >= DRAIN_CYCLES));
        end
    end

    task automatic applyStimulus(input logic v, input logic [10:0] c, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd, input logic fl);
        id_valid  = v;
        id_ctrl   = c;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        flush     = fl;
        id_pc     = $urandom;
        id_rd1    = $urandom;
        id_rd2    = $urandom;
        id_imm    = $urandom;
        id_funct3 = 3'($urandom);
        id_funct7 = 7'($urandom);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ex_valid"},   ex_valid,   1'b0);
        checkOutput({tag, "_ex_ctrl"},    ex_ctrl,    11'd0);
        checkOutput({tag, "_ex_pc"},      ex_pc,      32'd0);
        checkOutput({tag, "_ex_rd1"},     ex_rd1,     32'd0);
        checkOutput({tag, "_ex_rd"},      ex_rd,      5'd0);
        checkOutput({tag, "_stall"},      stall,      1'b0);
        checkOutput({tag, "_fetch_stop"}, fetch_stop, 1'b0);
        checkOutput({tag, "_halted"},     halted,     1'b0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, '0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        applyStimulus(1, C_LW, 5'($urandom), 5'($urandom), 5'($urandom), 0);
        #2 checkAllZero("reset0");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Normal capture, then a load-use pair.
        applyStimulus(1, C_ADD, 1, 2, 3, 0);
        @(negedge clk); checkOutput("add_nostall", stall, 1'b0); nextCycle();
        applyStimulus(1, C_LW, 1, 0, 5, 0);
        @(negedge clk);
        checkOutput("first_capture_valid", ex_valid, 1'b1);
        checkOutput("first_capture_rd", ex_rd, 5'd3);
        nextCycle();
        applyStimulus(1, C_ADD, 5, 2, 6, 0);
        @(negedge clk);
        checkOutput("loaduse_stall", stall, 1'b1);
        checkOutput("loaduse_lw_in_ex", ex_ctrl, C_LW);
        nextCycle();
        applyStimulus(1, C_ADD, 5, 2, 6, 0);
        @(negedge clk);
        checkOutput("loaduse_bubble", ex_valid, 1'b0);
        checkOutput("loaduse_one_cycle", stall, 1'b0);
        nextCycle();

        // No false hazards: x0 destination, unrelated registers.
        applyStimulus(1, C_LW, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("add_after_stall_valid", ex_valid, 1'b1);
        checkOutput("add_after_stall_rd", ex_rd, 5'd6);
        nextCycle();
        applyStimulus(1, C_ADD, 0, 0, 4, 0);
        @(negedge clk); checkOutput("x0_nohazard", stall, 1'b0); nextCycle();
        applyStimulus(1, C_LW, 1, 0, 5, 0);
        @(negedge clk); nextCycle();
        applyStimulus(1, C_ADD, 6, 7, 8, 0);
        @(negedge clk); checkOutput("unrelated_regs", stall, 1'b0); nextCycle();

        // Flush coinciding with a load-use hazard.
        applyStimulus(1, C_LW, 1, 0, 7, 0);
        @(negedge clk); nextCycle();
        applyStimulus(1, C_ADD, 3, 7, 9, 1);
        @(negedge clk); checkOutput("flush_beats_stall", stall, 1'b0); nextCycle();
        applyStimulus(0, '0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flush_bubble_valid", ex_valid, 1'b0);
        checkOutput("flush_bubble_ctrl", ex_ctrl, 11'd0);
        nextCycle();

        // Back-to-back dependent loads.
        applyStimulus(1, C_LW, 1, 0, 8, 0);
        @(negedge clk); nextCycle();
        applyStimulus(1, C_LW, 8, 0, 9, 0);
        @(negedge clk); checkOutput("b2b_stall1", stall, 1'b1); nextCycle();
        applyStimulus(1, C_LW, 8, 0, 9, 0);
        @(negedge clk); nextCycle();
        applyStimulus(1, C_ADD, 9, 1, 10, 0);
        @(negedge clk); checkOutput("b2b_stall2", stall, 1'b1); nextCycle();
        applyStimulus(1, C_ADD, 9, 1, 10, 0);
        @(negedge clk); checkOutput("b2b_release", stall, 1'b0); nextCycle();

        // Halt drain, with a late flush that must be ignored.
        applyStimulus(1, C_HALT, 0, 0, 0, 0);
        @(negedge clk); checkOutput("halt_in_id_fetch", fetch_stop, 1'b0); nextCycle();
        for (int k = 0; k < 25; k++) begin
            applyStimulus(1, C_ADD, 5'($urandom), 5'($urandom), 5'($urandom), k == 1);
            @(negedge clk);
            if (k == 0) checkOutput("halt_in_ex_ctrl", ex_ctrl, C_HALT_ONLY);
            checkOutput("drain_fetch_stop", fetch_stop, 1'b1);
            checkOutput("drain_halted", halted, k >= DRAIN_CYCLES);
            nextCycle();
        end

        // Asynchronous reset out of HALTED with live inputs.
        @(negedge clk);
        #2 reset = 1'b0;
        applyStimulus(1, C_LW, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
        #1 checkAllZero("midreset");
        nextCycle();
        reset = 1'b1;

        // Halt cancelled by a flush while it sits in EX.
        applyStimulus(1, C_ADD, 1, 2, 3, 0);
        @(negedge clk); nextCycle();
        applyStimulus(1, C_HALT, 0, 0, 0, 0);
        @(negedge clk); nextCycle();
        applyStimulus(1, C_ADD, 1, 2, 3, 1);
        @(negedge clk); checkOutput("cancel_fetch_before", fetch_stop, 1'b1); nextCycle();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, C_ADD, 1, 2, 3, 0);
            @(negedge clk);
            checkOutput("cancel_fetch_after", fetch_stop, 1'b0);
            checkOutput("cancel_never_halts", halted, 1'b0);
            nextCycle();
        end

        // HALT in ID together with a flush is discarded.
        applyStimulus(1, C_HALT, 0, 0, 0, 1);
        @(negedge clk); nextCycle();
        applyStimulus(0, '0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flush_halt_fetch", fetch_stop, 1'b0);
        checkOutput("flush_halt_bubble", ex_valid, 1'b0);
        nextCycle();

        // Mixed traffic on a small register window so hazards occur often.
        for (int k = 0; k < 200; k++) begin
            logic [10:0] c;
            c = 11'($urandom) & 11'h7FE;
            applyStimulus(1'($urandom), c, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
            nextCycle();
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
